tone_envelope_player: RTL and testbench
=======================================

Name: tone_envelope_player

Overview:
Audio back end for the game controller's sound interface. It consumes the controller's enable_sound level and sound_freq value (500 Hz win tone, 950 Hz lose tone) and synthesises the tone using a phase-accumulator (DDS) oscillator. The output is gated by an attack/sustain/release amplitude envelope so tones start and stop without clicks. It drives a 1-bit square wave for a speaker pin and a signed sample stream for the audio codec.

Parameters:
PHASE_W, 32, phase accumulator width
INC_PER_HZ, 86, phase increment per Hz of sound_freq (2^32 / 50 MHz, rounded)
AMP_MAX, 8192, sustain amplitude (must be < 2^15)
AMP_STEP, 64, amplitude change per envelope tick
STEP_CYCLES, 5000, clk cycles per envelope tick
SAMPLE_DIV, 1042, clk cycles per sample_valid strobe (~48 kHz)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous, active-low reset
enable_sound  in  1  tone request level from game controller
sound_freq  in  10  tone frequency in Hz, unsigned
tone_out  out  1  square wave, 0 when idle
sample  out  16  signed sample: +amp / -amp
sample_valid  out  1  one-cycle strobe every SAMPLE_DIV cycles
busy  out  1  high in any state other than IDLE
env_state  out  2  IDLE=0, ATTACK=1, SUSTAIN=2, RELEASE=3

Behaviour:
- Reset: state IDLE. phase, amp, step_cnt, sample_cnt, freq_lat, en_d, tone_out, sample and sample_valid are all 0. Reset acts immediately from any state, including mid-tone.
- Start detect: en_d is enable_sound registered. rise = enable_sound & !en_d. sound_freq is sampled in the same cycle rise is seen, because the controller updates both on the same edge.
- IDLE: on rise with sound_freq != 0, latch freq_lat, clear phase, amp and step_cnt, and go to ATTACK next cycle. On rise with sound_freq == 0, stay IDLE.
- phase_inc = freq_lat * INC_PER_HZ, computed unsigned and zero-extended to PHASE_W. Every non-IDLE cycle, phase <= phase + phase_inc, wrapping mod 2^PHASE_W. In IDLE, phase holds.
- tone_out = phase[PHASE_W-1], registered, forced to 0 in IDLE.
- Envelope tick: step_cnt counts 0..STEP_CYCLES-1 in non-IDLE states. tick fires when step_cnt == STEP_CYCLES-1, then step_cnt returns to 0.
- ATTACK: on tick, amp <= min(amp + AMP_STEP, AMP_MAX). Go to SUSTAIN on the cycle after amp == AMP_MAX. If enable_sound == 0, go to RELEASE at the current amp; this check takes priority over the tick-driven transition.
- SUSTAIN: amp holds. Go to RELEASE when enable_sound == 0.
- RELEASE: on tick, amp <= (amp > AMP_STEP) ? amp - AMP_STEP : 0. When amp == 0, go to IDLE.
- Retrigger: a rise during RELEASE with sound_freq != 0 latches the new freq_lat and goes to ATTACK from the current amp. phase is not cleared, so the waveform stays continuous. A rise with sound_freq == 0 is ignored.
- freq_lat changes only on an accepted rise. sound_freq changes mid-tone are ignored.
- sample is registered every cycle: 0 in IDLE, otherwise tone_out ? +amp : -amp, two's complement, 16 bits.
- sample_cnt is free-running 0..SAMPLE_DIV-1, also in IDLE. sample_valid = 1 for the single cycle when sample_cnt == SAMPLE_DIV-1.
- busy = (state != IDLE). env_state is the state register.
- Simultaneous events: a tick and a fall of enable_sound in the same ATTACK cycle apply the tick increment to amp, then move to RELEASE.

Test Plan:
Sim parameters: PHASE_W=20, INC_PER_HZ=86, AMP_MAX=256, AMP_STEP=64, STEP_CYCLES=4, SAMPLE_DIV=8.
1. Reset, then idle 20 cycles -> tone_out=0, sample=0, busy=0, env_state=0. sample_valid pulses every 8 cycles.
2. enable_sound rises with sound_freq=500 -> ATTACK next cycle, phase_inc=43000. amp steps 64/128/192/256 at ticks 1-4, then SUSTAIN. First tone_out high 13 cycles after start. sample = +/-256 in SUSTAIN.
3. From SUSTAIN, drop enable_sound -> RELEASE. amp goes 192/128/64/0 over 4 ticks, then IDLE. busy=0, sample=0, tone_out=0.
4. In SUSTAIN at 500 Hz, change sound_freq to 950 -> phase_inc stays 43000 and tone period is unchanged.
5. In RELEASE at amp=128, pulse enable_sound high with sound_freq=950 -> ATTACK from 128 with phase_inc=81700, phase continuous, reaches 256 after 2 ticks.
6. Rise with sound_freq=0 -> stays IDLE. Separately, assert resetN=0 mid-ATTACK -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/tone_envelope_player.sv
// tone_envelope_player
// DDS square-wave tone generator with an attack/sustain/release amplitude
// envelope. A rising edge of enable_sound (with a non-zero frequency) starts
// or retriggers a tone; dropping enable_sound fades it out. Outputs are a
// 1-bit speaker square wave and a signed +/-amp sample stream with a
// periodic sample_valid strobe.
module tone_envelope_player #(
  parameter int unsigned PHASE_W     = 32,
  parameter int unsigned INC_PER_HZ  = 86,
  parameter int unsigned AMP_MAX     = 8192,
  parameter int unsigned AMP_STEP    = 64,
  parameter int unsigned STEP_CYCLES = 5000,
  parameter int unsigned SAMPLE_DIV  = 1042
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        enable_sound,
  input  logic [9:0]  sound_freq,
  output logic        tone_out,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic [1:0]  env_state
);

  localparam int unsigned STEP_W   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned SAMPLE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [STEP_W-1:0]   STEP_LAST   = STEP_W'(STEP_CYCLES - 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_DIV - 1);
  localparam logic [PHASE_W-1:0]  INC_C       = PHASE_W'(INC_PER_HZ);
  localparam logic [15:0]         AMP_MAX_C   = 16'(AMP_MAX);
  localparam logic [15:0]         AMP_STEP_C  = 16'(AMP_STEP);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } env_state_e;

  // Envelope / oscillator state
  env_state_e            state_q, state_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [15:0]           amp_q, amp_d;
  logic [STEP_W-1:0]     step_cnt_q, step_cnt_d;
  logic [SAMPLE_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [9:0]            freq_lat_q, freq_lat_d;
  logic                  en_q;

  // Registered outputs
  logic                  tone_q, tone_d;
  logic [15:0]           sample_q, sample_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  busy_q, busy_d;

  // Derived control
  logic                  rise_s;
  logic                  start_ok_s;
  logic                  tick_s;
  logic [PHASE_W-1:0]    phase_inc_s;
  logic [16:0]           amp_sum_s;
  logic [15:0]           amp_up_s;
  logic [15:0]           amp_down_s;

  assign rise_s      = enable_sound & ~en_q;
  assign start_ok_s  = rise_s & (sound_freq != 10'd0);
  assign tick_s      = (state_q != ST_IDLE) & (step_cnt_q == STEP_LAST);
  assign phase_inc_s = PHASE_W'(freq_lat_q) * INC_C;

  // Saturating envelope step up and floored step down.
  always_comb begin
    amp_sum_s = {1'b0, amp_q} + {1'b0, AMP_STEP_C};
    if (amp_sum_s > {1'b0, AMP_MAX_C}) begin
      amp_up_s = AMP_MAX_C;
    end else begin
      amp_up_s = amp_sum_s[15:0];
    end
    if (amp_q > AMP_STEP_C) begin
      amp_down_s = amp_q - AMP_STEP_C;
    end else begin
      amp_down_s = 16'd0;
    end
  end

  // Envelope FSM next-state, oscillator phase and tick counter.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    amp_d      = amp_q;
    step_cnt_d = step_cnt_q;
    freq_lat_d = freq_lat_q;

    if (state_q == ST_IDLE) begin
      step_cnt_d = '0;
    end else begin
      phase_d = phase_q + phase_inc_s;
      if (tick_s) begin
        step_cnt_d = '0;
      end else begin
        step_cnt_d = step_cnt_q + STEP_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          freq_lat_d = sound_freq;
          phase_d    = '0;
          amp_d      = 16'd0;
          step_cnt_d = '0;
          state_d    = ST_ATTACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ATTACK: begin
        if (tick_s) begin
          amp_d = amp_up_s;
        end else begin
          amp_d = amp_q;
        end
        // A released request wins over the ramp reaching full scale.
        if (!enable_sound) begin
          state_d = ST_RELEASE;
        end else if (amp_q == AMP_MAX_C) begin
          state_d = ST_SUSTAIN;
        end else begin
          state_d = ST_ATTACK;
        end
      end
      ST_SUSTAIN: begin
        if (!enable_sound) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_SUSTAIN;
        end
      end
      ST_RELEASE: begin
        // Retrigger keeps amp and phase so the waveform stays continuous.
        if (start_ok_s) begin
          freq_lat_d = sound_freq;
          state_d    = ST_ATTACK;
        end else if (amp_q == 16'd0) begin
          state_d = ST_IDLE;
        end else if (tick_s) begin
          amp_d = amp_down_s;
        end else begin
          amp_d = amp_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        amp_d   = 16'd0;
      end
    endcase
  end

  // Output next values, aligned with the state/phase/amp being loaded.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    tone_d = busy_d & phase_d[PHASE_W-1];
    if (!busy_d) begin
      sample_d = 16'd0;
    end else if (tone_d) begin
      sample_d = amp_d;
    end else begin
      sample_d = 16'd0 - amp_d;
    end
    if (sample_cnt_q == SAMPLE_LAST) begin
      sample_cnt_d = '0;
    end else begin
      sample_cnt_d = sample_cnt_q + SAMPLE_W'(1);
    end
    sample_valid_d = (sample_cnt_d == SAMPLE_LAST);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= ST_IDLE;
      phase_q        <= '0;
      amp_q          <= 16'd0;
      step_cnt_q     <= '0;
      sample_cnt_q   <= '0;
      freq_lat_q     <= 10'd0;
      en_q           <= 1'b0;
      tone_q         <= 1'b0;
      sample_q       <= 16'd0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      amp_q          <= amp_d;
      step_cnt_q     <= step_cnt_d;
      sample_cnt_q   <= sample_cnt_d;
      freq_lat_q     <= freq_lat_d;
      en_q           <= enable_sound;
      tone_q         <= tone_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign tone_out     = tone_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign env_state    = state_q;

endmodule

// File: tb/tb_tone_envelope_player.sv
// Self-checking bench for tone_envelope_player: directed steps from the test
// plan followed by randomized enable/frequency traffic, all checked against
// an arithmetic reference model of the envelope and DDS oscillator.
module tb_tone_envelope_player;

  localparam int PW    = 20;
  localparam int INC   = 86;
  localparam int AMAX  = 256;
  localparam int ASTEP = 64;
  localparam int STEPC = 4;
  localparam int SDIV  = 8;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        enable_sound = 1'b0;
  logic [9:0]  sound_freq = 10'd0;
  logic        tone_out;
  logic [15:0] sample;
  logic        sample_valid;
  logic        busy;
  logic [1:0]  env_state;

  tone_envelope_player #(
    .PHASE_W(PW), .INC_PER_HZ(INC), .AMP_MAX(AMAX), .AMP_STEP(ASTEP),
    .STEP_CYCLES(STEPC), .SAMPLE_DIV(SDIV)
  ) dut (
    .clk(clk), .resetN(resetN), .enable_sound(enable_sound),
    .sound_freq(sound_freq), .tone_out(tone_out), .sample(sample),
    .sample_valid(sample_valid), .busy(busy), .env_state(env_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 attack, 2 sustain, 3 release
  int     m_state, m_amp, m_step, m_scnt, m_freq;
  bit     m_en;
  longint m_phase;

  function automatic void model_reset();
    m_state = 0; m_amp = 0; m_step = 0; m_scnt = 0; m_freq = 0;
    m_en = 1'b0; m_phase = 0;
  endfunction

  function automatic void model_step(bit en, int freq);
    bit rise, tick;
    int old_amp;
    rise    = en && !m_en;
    tick    = (m_state != 0) && (m_step == STEPC - 1);
    old_amp = m_amp;
    if (m_state == 0) begin
      if (rise && freq != 0) begin
        m_freq = freq; m_phase = 0; m_amp = 0; m_step = 0; m_state = 1;
      end
    end else begin
      m_phase = (m_phase + longint'(m_freq) * INC) % (longint'(1) << PW);
      m_step  = tick ? 0 : m_step + 1;
      if (m_state == 1) begin
        if (tick) m_amp = (old_amp + ASTEP > AMAX) ? AMAX : old_amp + ASTEP;
        if (!en) m_state = 3;
        else if (old_amp == AMAX) m_state = 2;
      end else if (m_state == 2) begin
        if (!en) m_state = 3;
      end else begin
        if (rise && freq != 0) begin
          m_freq = freq; m_state = 1;
        end else if (old_amp == 0) begin
          m_state = 0;
        end else if (tick) begin
          m_amp = (old_amp > ASTEP) ? old_amp - ASTEP : 0;
        end
      end
    end
    m_en   = en;
    m_scnt = (m_scnt + 1) % SDIV;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic        e_tone;
    logic [15:0] e_sample;
    e_tone = (m_state != 0) && (((m_phase >> (PW - 1)) & 1) == 1);
    e_sample = 16'(m_amp);
    if (m_state == 0) e_sample = 16'd0;
    else if (!e_tone) e_sample = 16'd0 - e_sample;
    check("env_state", 32'(env_state), 32'(m_state));
    check("busy", 32'(busy), 32'(m_state != 0));
    check("tone_out", 32'(tone_out), 32'(e_tone));
    check("sample", 32'(sample), 32'(e_sample));
    check("sample_valid", 32'(sample_valid), 32'(m_scnt == SDIV - 1));
  endtask

  task automatic step(bit en, int freq);
    enable_sound = en;
    sound_freq   = 10'(freq);
    @(posedge clk);
    model_step(en, freq);
    #1;
    check_all();
  endtask

  initial begin
    int first_hi;
    int guard;
    int cur_freq;
    bit cur_en;

    // 1. reset and idle
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    resetN = 1'b1;
    repeat (20) step(1'b0, 0);

    // 2. start a 500 Hz tone, ramp to sustain
    first_hi = -1;
    step(1'b1, 500);
    for (int i = 1; i <= 30; i++) begin
      step(1'b1, 500);
      if (first_hi < 0 && tone_out === 1'b1) first_hi = i;
    end
    check("first_tone_high_cycle", 32'(first_hi), 32'd13);
    check("sustain_state", 32'(env_state), 32'd2);
    check("sustain_mag", 32'(sample === 16'd256 || sample === 16'hFF00), 32'd1);

    // 3. release to idle
    repeat (25) step(1'b0, 500);
    check("idle_after_release", 32'(busy), 32'd0);

    // 4. start again, change frequency mid-tone (ignored)
    step(1'b1, 500);
    repeat (20) step(1'b1, 500);
    repeat (40) step(1'b1, 950);

    // 5. release to amp 128, then retrigger at 950 Hz
    guard = 0;
    step(1'b0, 950);
    while (m_amp != 128 && guard < 40) begin
      step(1'b0, 950);
      guard++;
    end
    check("release_reached_128", 32'(m_amp), 32'd128);
    step(1'b1, 950);
    check("retrigger_attack", 32'(env_state), 32'd1);
    repeat (12) step(1'b1, 950);
    check("retrigger_full_amp", 32'(sample === 16'd256 || sample === 16'hFF00), 32'd1);
    repeat (20) step(1'b0, 950);

    // 6. zero-frequency rise is ignored; reset mid-attack
    step(1'b1, 0);
    repeat (5) step(1'b1, 0);
    check("zero_freq_idle", 32'(busy), 32'd0);
    step(1'b0, 0);
    step(1'b1, 500);
    repeat (6) step(1'b1, 500);
    #2;
    resetN = 1'b0;
    enable_sound = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    resetN = 1'b1;
    repeat (3) step(1'b0, 0);

    // 7. randomized traffic
    cur_en = 1'b0;
    cur_freq = 500;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) cur_en = ~cur_en;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: cur_freq = 0;
          1: cur_freq = 500;
          2: cur_freq = 950;
          default: cur_freq = int'($urandom_range(0, 1023));
        endcase
      end
      step(cur_en, cur_freq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
